// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: widths, control-bundle bit map,
// and the ID/EX pipeline register layout.
package mips_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int CTRL_W = 8;
  localparam int CNT_W  = 16;

  // Control bundle bit positions
  localparam int CTRL_REGWRITE = 0;
  localparam int CTRL_MEMREAD  = 1;
  localparam int CTRL_MEMWRITE = 2;
  localparam int CTRL_MEMTOREG = 3;
  localparam int CTRL_ALUSRC   = 4;
  localparam int CTRL_REGDST   = 5;
  localparam int CTRL_ALUOP_LO = 6;
  localparam int CTRL_ALUOP_HI = 7;

  localparam logic [REG_W-1:0] REG_ZERO = '0;

  // Contents of the EX slot
  typedef struct packed {
    logic              valid;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] imm;
    logic [CTRL_W-1:0] ctrl;
  } ex_reg_t;

  // Saturating increment: holds at all-ones instead of wrapping
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + CNT_W'(1);
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-side, write-back-side and EX-side signals of the ID/EX stage.
// Handshake: there is no valid/ready pair on the ID side; id_valid marks a
// real instruction, and the stage consumes the decode slot on every rising
// edge where stall is low. When stall is high the producer must hold its
// decode slot unchanged. ex_valid marks a real instruction in the EX slot;
// ex_hold from EX freezes the EX slot and raises stall.
interface id_ex_stage_if;
  import mips_pkg::*;

  logic              id_valid;
  logic [REG_W-1:0]  id_rs;
  logic [REG_W-1:0]  id_rt;
  logic [REG_W-1:0]  id_rd;
  logic              id_uses_rt;
  logic [DATA_W-1:0] ReadData1;
  logic [DATA_W-1:0] ReadData2;
  logic [DATA_W-1:0] id_imm;
  logic [CTRL_W-1:0] id_ctrl;
  logic              wb_RegWrite;
  logic [REG_W-1:0]  wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              flush;
  logic              ex_hold;
  logic              stall;
  logic              ex_valid;
  logic [REG_W-1:0]  ex_rs;
  logic [REG_W-1:0]  ex_rt;
  logic [REG_W-1:0]  ex_rd;
  logic [DATA_W-1:0] ex_a;
  logic [DATA_W-1:0] ex_b;
  logic [DATA_W-1:0] ex_imm;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [CNT_W-1:0]  bubble_cnt;

  // Upstream side: decode, register file, write-back and EX control
  modport master (
    output id_valid, id_rs, id_rt, id_rd, id_uses_rt, ReadData1, ReadData2,
           id_imm, id_ctrl, wb_RegWrite, wb_rd, wb_data, flush, ex_hold,
    input  stall, ex_valid, ex_rs, ex_rt, ex_rd, ex_a, ex_b, ex_imm,
           ex_ctrl, bubble_cnt
  );

  // The ID/EX stage itself
  modport slave (
    input  id_valid, id_rs, id_rt, id_rd, id_uses_rt, ReadData1, ReadData2,
           id_imm, id_ctrl, wb_RegWrite, wb_rd, wb_data, flush, ex_hold,
    output stall, ex_valid, ex_rs, ex_rt, ex_rd, ex_a, ex_b, ex_imm,
           ex_ctrl, bubble_cnt
  );
endinterface

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detection: a load in EX whose destination (rt) is a source
// of the instruction in decode.
module hazard_detect
  import mips_pkg::*;
(
  input  logic             ex_valid,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  output logic             lu
);

  // Compare load destination against the decode-stage sources
  always_comb begin
    lu = ex_valid && ex_memread && (ex_rt != REG_ZERO) && id_valid &&
         ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with write-back bypass, load-use bubble insertion,
// flush/hold handling and a saturating bubble counter.
module id_ex_stage
  import mips_pkg::*;
(
  input  logic    Clk,
  input  logic    reset,
  id_ex_stage_if.slave bus
);

  ex_reg_t           ex_q, ex_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] op_a, op_b;
  logic              lu;

  hazard_detect u_hazard (
    .ex_valid   (ex_q.valid),
    .ex_memread (ex_q.ctrl[CTRL_MEMREAD]),
    .ex_rt      (ex_q.rt),
    .id_valid   (bus.id_valid),
    .id_rs      (bus.id_rs),
    .id_rt      (bus.id_rt),
    .id_uses_rt (bus.id_uses_rt),
    .lu         (lu)
  );

  // Operand select: r0 reads zero, otherwise a same-cycle WB write wins
  always_comb begin
    op_a = bus.ReadData1;
    if (bus.id_rs == REG_ZERO)
      op_a = '0;
    else if (bus.wb_RegWrite && (bus.wb_rd == bus.id_rs))
      op_a = bus.wb_data;

    op_b = bus.ReadData2;
    if (bus.id_rt == REG_ZERO)
      op_b = '0;
    else if (bus.wb_RegWrite && (bus.wb_rd == bus.id_rt))
      op_b = bus.wb_data;
  end

  // Next EX slot contents: flush > hold > load-use bubble > normal load.
  // A bubble only clears valid/ctrl; the data fields are don't-care.
  always_comb begin
    ex_d  = ex_q;
    cnt_d = cnt_q;
    if (bus.flush) begin
      ex_d.valid = 1'b0;
      ex_d.ctrl  = '0;
      cnt_d      = sat_inc(cnt_q);
    end else if (bus.ex_hold) begin
      ex_d  = ex_q;
    end else if (lu) begin
      ex_d.valid = 1'b0;
      ex_d.ctrl  = '0;
      cnt_d      = sat_inc(cnt_q);
    end else begin
      ex_d.valid = bus.id_valid;
      ex_d.ctrl  = bus.id_valid ? bus.id_ctrl : '0;
      ex_d.rs    = bus.id_rs;
      ex_d.rt    = bus.id_rt;
      ex_d.rd    = bus.id_rd;
      ex_d.a     = op_a;
      ex_d.b     = op_b;
      ex_d.imm   = bus.id_imm;
    end
  end

  // Pipeline register and bubble counter
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      ex_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.stall      = bus.ex_hold || (lu && !bus.flush);
  assign bus.ex_valid   = ex_q.valid;
  assign bus.ex_rs      = ex_q.rs;
  assign bus.ex_rt      = ex_q.rt;
  assign bus.ex_rd      = ex_q.rd;
  assign bus.ex_a       = ex_q.a;
  assign bus.ex_b       = ex_q.b;
  assign bus.ex_imm     = ex_q.imm;
  assign bus.ex_ctrl    = ex_q.ctrl;
  assign bus.bubble_cnt = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage with a queue-based scoreboard.
module tb_id_ex_stage;
  import mips_pkg::*;

  typedef struct packed {
    logic              valid;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  rd;
    logic              uses_rt;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] imm;
    logic [CTRL_W-1:0] ctrl;
    logic              wb_we;
    logic [REG_W-1:0]  wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic              flush;
    logic              hold;
  } in_t;

  typedef struct packed {
    logic              chk_data;
    logic              valid;
    logic [CTRL_W-1:0] ctrl;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] imm;
    logic [CNT_W-1:0]  cnt;
  } exp_t;

  localparam int EXP_W = $bits(exp_t);

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  logic [EXP_W-1:0] exp_q[$];

  id_ex_stage_if bus();

  id_ex_stage dut (
    .Clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic in_t mk(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                             input logic [4:0] rd, input logic uses_rt,
                             input logic [31:0] rd1, input logic [31:0] rd2,
                             input logic [31:0] imm, input logic [7:0] ctrl);
    in_t r;
    r = '0;
    r.valid = v; r.rs = rs; r.rt = rt; r.rd = rd; r.uses_rt = uses_rt;
    r.rd1 = rd1; r.rd2 = rd2; r.imm = imm; r.ctrl = ctrl;
    return r;
  endfunction

  function automatic exp_t ld(input logic [7:0] ctrl, input logic [4:0] rs,
                              input logic [4:0] rt, input logic [4:0] rd,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] imm, input logic [15:0] cnt);
    exp_t e;
    e.chk_data = 1'b1; e.valid = 1'b1; e.ctrl = ctrl;
    e.rs = rs; e.rt = rt; e.rd = rd; e.a = a; e.b = b; e.imm = imm; e.cnt = cnt;
    return e;
  endfunction

  function automatic exp_t bub(input logic [15:0] cnt);
    exp_t e;
    e = '0;
    e.cnt = cnt;
    return e;
  endfunction

  // Driver tasks
  task automatic apply(input in_t v);
    bus.id_valid    = v.valid;
    bus.id_rs       = v.rs;
    bus.id_rt       = v.rt;
    bus.id_rd       = v.rd;
    bus.id_uses_rt  = v.uses_rt;
    bus.ReadData1   = v.rd1;
    bus.ReadData2   = v.rd2;
    bus.id_imm      = v.imm;
    bus.id_ctrl     = v.ctrl;
    bus.wb_RegWrite = v.wb_we;
    bus.wb_rd       = v.wb_rd;
    bus.wb_data     = v.wb_data;
    bus.flush       = v.flush;
    bus.ex_hold     = v.hold;
  endtask

  // Called 2 time units after a rising edge; returns at the same phase.
  task automatic step(input in_t v, input logic exp_stall, input exp_t e);
    apply(v);
    #1 chk("stall", 32'(bus.stall), 32'(exp_stall));
    @(posedge clk);
    #1 exp_q.push_back(EXP_W'(e));
    #1;
  endtask

  // Scoreboard monitor: compare EX slot against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_t'(exp_q.pop_front());
        chk("ex_valid", 32'(bus.ex_valid), 32'(e.valid));
        chk("ex_ctrl", 32'(bus.ex_ctrl), 32'(e.ctrl));
        chk("bubble_cnt", 32'(bus.bubble_cnt), 32'(e.cnt));
        if (e.chk_data) begin
          chk("ex_rs", 32'(bus.ex_rs), 32'(e.rs));
          chk("ex_rt", 32'(bus.ex_rt), 32'(e.rt));
          chk("ex_rd", 32'(bus.ex_rd), 32'(e.rd));
          chk("ex_a", bus.ex_a, e.a);
          chk("ex_b", bus.ex_b, e.b);
          chk("ex_imm", bus.ex_imm, e.imm);
        end
      end
    end
  end

  // Stimulus
  initial begin
    in_t v;
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    apply(mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 8'h00));
    #12;
    chk("reset ex_valid", 32'(bus.ex_valid), 32'd0);
    chk("reset ex_ctrl", 32'(bus.ex_ctrl), 32'd0);
    chk("reset bubble_cnt", 32'(bus.bubble_cnt), 32'd0);
    chk("reset stall", 32'(bus.stall), 32'd0);
    @(posedge clk);
    #2 reset = 1'b0;

    // Normal pass
    v = mk(1'b1, 5'd8, 5'd9, 5'd10, 1'b1, 32'h1, 32'h2, 32'h10, 8'h31);
    step(v, 1'b0, ld(8'h31, 5'd8, 5'd9, 5'd10, 32'h1, 32'h2, 32'h10, 16'd0));
    // WB bypass on rt
    v.wb_we = 1'b1; v.wb_rd = 5'd9; v.wb_data = 32'hDEAD;
    step(v, 1'b0, ld(8'h31, 5'd8, 5'd9, 5'd10, 32'h1, 32'hDEAD, 32'h10, 16'd0));
    // WB bypass on rs
    v.wb_rd = 5'd8; v.wb_data = 32'hBEEF;
    step(v, 1'b0, ld(8'h31, 5'd8, 5'd9, 5'd10, 32'hBEEF, 32'h2, 32'h10, 16'd0));
    // Register zero: bypass suppressed and file data ignored
    v = mk(1'b1, 5'd0, 5'd0, 5'd10, 1'b1, 32'h5, 32'h2, 32'h10, 8'h31);
    v.wb_we = 1'b1; v.wb_rd = 5'd0; v.wb_data = 32'hDEAD;
    step(v, 1'b0, ld(8'h31, 5'd0, 5'd0, 5'd10, 32'h0, 32'h0, 32'h10, 16'd0));

    // Load-use via rs
    v = mk(1'b1, 5'd3, 5'd18, 5'd0, 1'b0, 32'h100, 32'h7, 32'h4, 8'h1B);
    step(v, 1'b0, ld(8'h1B, 5'd3, 5'd18, 5'd0, 32'h100, 32'h7, 32'h4, 16'd0));
    v = mk(1'b1, 5'd18, 5'd5, 5'd6, 1'b1, 32'h11, 32'h22, 32'h0, 8'hA1);
    step(v, 1'b1, bub(16'd1));
    step(v, 1'b0, ld(8'hA1, 5'd18, 5'd5, 5'd6, 32'h11, 32'h22, 32'h0, 16'd1));

    // Flush beats load-use (hazard through rt)
    v = mk(1'b1, 5'd3, 5'd18, 5'd0, 1'b0, 32'h200, 32'h7, 32'h8, 8'h1B);
    step(v, 1'b0, ld(8'h1B, 5'd3, 5'd18, 5'd0, 32'h200, 32'h7, 32'h8, 16'd1));
    v = mk(1'b1, 5'd5, 5'd18, 5'd6, 1'b1, 32'h11, 32'h22, 32'h0, 8'hA1);
    v.flush = 1'b1;
    step(v, 1'b0, bub(16'd2));

    // rt match ignored when rt is not a source
    v = mk(1'b1, 5'd3, 5'd18, 5'd0, 1'b0, 32'h300, 32'h7, 32'h8, 8'h1B);
    step(v, 1'b0, ld(8'h1B, 5'd3, 5'd18, 5'd0, 32'h300, 32'h7, 32'h8, 16'd2));
    v = mk(1'b1, 5'd4, 5'd18, 5'd6, 1'b0, 32'h44, 32'h55, 32'h20, 8'hA1);
    step(v, 1'b0, ld(8'hA1, 5'd4, 5'd18, 5'd6, 32'h44, 32'h55, 32'h20, 16'd2));

    // Hold for three cycles with changing decode inputs
    for (int i = 0; i < 3; i++) begin
      v = mk(1'b1, 5'(i + 1), 5'(i + 2), 5'(i + 3), 1'b1, 32'(i * 7), 32'(i * 9),
             32'(i), 8'h5A);
      v.hold = 1'b1;
      step(v, 1'b1, ld(8'hA1, 5'd4, 5'd18, 5'd6, 32'h44, 32'h55, 32'h20, 16'd2));
    end
    // Flush beats hold
    v.flush = 1'b1;
    step(v, 1'b1, bub(16'd3));
    // Invalid slot loaded normally is not a bubble
    v = mk(1'b0, 5'd1, 5'd2, 5'd3, 1'b1, 32'h9, 32'h9, 32'h9, 8'hFF);
    step(v, 1'b0, bub(16'd3));

    // Reset asserted in the middle of a load-use stall
    v = mk(1'b1, 5'd1, 5'd18, 5'd0, 1'b0, 32'h400, 32'h9, 32'hC, 8'h1B);
    step(v, 1'b0, ld(8'h1B, 5'd1, 5'd18, 5'd0, 32'h400, 32'h9, 32'hC, 16'd3));
    v = mk(1'b1, 5'd18, 5'd7, 5'd6, 1'b1, 32'h66, 32'h77, 32'h0, 8'hA1);
    apply(v);
    #1 chk("pre-reset stall", 32'(bus.stall), 32'd1);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("mid reset ex_valid", 32'(bus.ex_valid), 32'd0);
    chk("mid reset ex_ctrl", 32'(bus.ex_ctrl), 32'd0);
    chk("mid reset bubble_cnt", 32'(bus.bubble_cnt), 32'd0);
    chk("mid reset ex_a", bus.ex_a, 32'd0);
    chk("mid reset stall", 32'(bus.stall), 32'd0);
    @(posedge clk);
    #2 reset = 1'b0;
    // First edge after release loads normally
    step(v, 1'b0, ld(8'hA1, 5'd18, 5'd7, 5'd6, 32'h66, 32'h77, 32'h0, 16'd0));

    // Saturation: drive the counter to all-ones with back-to-back flushes
    v.flush = 1'b1;
    apply(v);
    repeat (65535) @(posedge clk);
    #2 chk("bubble_cnt at max", 32'(bus.bubble_cnt), 32'hFFFF);
    step(v, 1'b0, bub(16'hFFFF));
    v = mk(1'b1, 5'd2, 5'd3, 5'd4, 1'b1, 32'hA, 32'hB, 32'hC, 8'h31);
    step(v, 1'b0, ld(8'h31, 5'd2, 5'd3, 5'd4, 32'hA, 32'hB, 32'hC, 16'hFFFF));

    // Drain the scoreboard, bounded
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0 pending", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
